blk_c7d7dc: RTL

WEIGHT_S_LOADER_WQ_WEIGHT_S_SUM_MMAP_M_AXI_RDATA_TRACKER -- requirements
Module: weight_s_loader_wq_weight_s_sum_mmap_m_axi_rdata_tracker

---
 rtl/blk_c7d7dc.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/blk_c7d7dc.sv
// ---------------------------------------------------------------------------
// blk_c7d7dc -- AXI read-data tracker for the weight_s_sum memory-mapped port.
//
// Pairs AXI R beats with per-burst control entries ({INFO, LEN}) queued in a
// small FIFO. Beats are counted against the head entry's LEN; the final beat
// of a burst pops the entry, and if the entry is the last burst of a user
// request (INFO=1) the forwarded beat is tagged with out_DATA_LAST. Data is
// forwarded through one output register stage at one beat per clock.
//
// Ports:
//   clk, reset        clock; synchronous active-low reset (0 = reset)
//   clk_en            global enable, 0 freezes every register
//   in_CTRL_*         control entry push (INFO, LEN = beats-1, VALID)
//   out_CTRL_READY    control FIFO has room
//   in_R*             AXI R channel (RDATA, RLAST, RRESP, RVALID)
//   out_RREADY        AXI R ready
//   out_DATA*         user data stream (DATA, DATA_LAST, DATA_VALID)
//   in_DATA_READY     user sink ready
//   out_ERR           sticky flags: [0] RRESP error, [1] RLAST mismatch
// ---------------------------------------------------------------------------
module blk_c7d7dc #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic                  in_CTRL_INFO,
    input  logic [7:0]            in_CTRL_LEN,
    input  logic                  in_CTRL_VALID,
    output logic                  out_CTRL_READY,
    input  logic [DATA_WIDTH-1:0] in_RDATA,
    input  logic                  in_RLAST,
    input  logic [1:0]            in_RRESP,
    input  logic                  in_RVALID,
    output logic                  out_RREADY,
    output logic [DATA_WIDTH-1:0] out_DATA,
    output logic                  out_DATA_LAST,
    output logic                  out_DATA_VALID,
    input  logic                  in_DATA_READY,
    output logic [1:0]            out_ERR
);

    localparam int PTR_W = (CTRL_DEPTH > 1) ? $clog2(CTRL_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(CTRL_DEPTH);

    // Control FIFO storage: entry = {INFO, LEN}. The head is read
    // combinationally so a new burst can start the cycle after the previous
    // one pops, keeping the stream bubble-free across burst boundaries.
    logic [8:0]            ctrl_mem [CTRL_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg;
    logic [CNT_W-1:0]      count_next;
    logic [7:0]            beat_cnt_reg;

    logic [DATA_WIDTH-1:0] data_reg;
    logic                  last_reg;
    logic                  valid_reg;
    logic [1:0]            err_reg;

    logic [8:0]            head;
    logic                  head_info;
    logic [7:0]            head_len;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  push;
    logic                  beat_accept;
    logic                  beat_final;
    logic                  pop;

    assign head       = ctrl_mem[rd_ptr_reg];
    assign head_info  = head[8];
    assign head_len   = head[7:0];
    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == DEPTH_CNT);

    // Readies are masked by reset so nothing handshakes while held in reset.
    assign out_CTRL_READY = clk_en & reset & ~fifo_full;
    assign out_RREADY     = clk_en & reset & ~fifo_empty &
                            (~valid_reg | in_DATA_READY);

    assign push        = in_CTRL_VALID & out_CTRL_READY;
    assign beat_accept = in_RVALID & out_RREADY;
    // Burst boundaries follow the control LEN, never the incoming RLAST.
    assign beat_final  = (beat_cnt_reg == head_len);
    assign pop         = beat_accept & beat_final;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Storage has no reset; only entries between the pointers are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            ctrl_mem[wr_ptr_reg] <= {in_CTRL_INFO, in_CTRL_LEN};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            beat_cnt_reg <= '0;
            data_reg     <= '0;
            last_reg     <= 1'b0;
            valid_reg    <= 1'b0;
            err_reg      <= 2'b00;
        end else if (clk_en) begin
            // Pointers wrap naturally since CTRL_DEPTH is a power of two.
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;

            if (beat_accept) begin
                beat_cnt_reg <= beat_final ? 8'd0 : beat_cnt_reg + 8'd1;
            end

            // Output stage: load on accept (which also covers drain+accept in
            // the same cycle), otherwise release the held beat once taken.
            if (beat_accept) begin
                data_reg  <= in_RDATA;
                last_reg  <= beat_final & head_info;
                valid_reg <= 1'b1;
            end else if (in_DATA_READY) begin
                last_reg  <= 1'b0;
                valid_reg <= 1'b0;
            end

            if (beat_accept && (in_RRESP != 2'b00)) begin
                err_reg[0] <= 1'b1;
            end
            if (beat_accept && (in_RLAST != beat_final)) begin
                err_reg[1] <= 1'b1;
            end
        end
    end

    assign out_DATA       = data_reg;
    assign out_DATA_LAST  = last_reg;
    assign out_DATA_VALID = valid_reg;
    assign out_ERR        = err_reg;

endmodule
